hp_port_remap_bridge: RTL

- Parametrised bridge between the simulator shim's AXI master port (FPGA memory traffic) and a Zynq HP/ACP slave port.
- Registers AR/AW through full-throughput skid buffers and relocates addresses into a configurable DDR window.
- Drives the fixed burst/cache/prot/qos/region/lock attributes.
- Bounds outstanding reads/writes, flags out-of-window addresses, and provides a drain/idle handshake for safe host-side reset.

---
 rtl/hp_port_remap_bridge.sv | 287 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/hp_port_remap_bridge.sv
// Bridge from the simulator shim AXI master to a Zynq HP/ACP slave: skid-buffered AR/AW with
// DDR-window relocation, per-direction outstanding limits, error flags and a drain/idle handshake.

module hp_port_remap_skid #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         drain_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    input  logic         issue_en_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o,
    output logic         empty_o
);
    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   cnt_q;
    logic [1:0]   cnt_d;
    logic         rdy_q;
    logic         push;
    logic         pop;

    // Ready comes from a register so the upstream path never sees the downstream ready.
    assign in_ready_o  = rdy_q && !drain_i;
    assign out_valid_o = (cnt_q != 2'd0) && issue_en_i;
    assign out_data_o  = mem_q[rd_ptr_q];
    assign empty_o     = (cnt_q == 2'd0);
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 2'd1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
            rdy_q    <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_data_i;
                wr_ptr_q        <= !wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= !rd_ptr_q;
            end
            cnt_q <= cnt_d;
            rdy_q <= !drain_i && (cnt_d != 2'd2);
        end
    end
endmodule

module hp_port_remap_ostd #(
    parameter int MAX = 8,
    parameter int CW  = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inc_i,
    input  logic dec_i,
    output logic allow_o,
    output logic zero_o,
    output logic underflow_o
);
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign allow_o     = (cnt_q < CW'(MAX));
    assign zero_o      = (cnt_q == '0);
    assign underflow_o = dec_i && zero_o;

    // A completion with nothing outstanding is reported, never allowed to wrap the count.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i) begin
            cnt_d = cnt_q + CW'(1);
        end else if (dec_i && !inc_i && !zero_o) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

module hp_port_remap_bridge #(
    parameter int              ADDR_W          = 32,
    parameter int              DATA_W          = 64,
    parameter int              ID_W            = 6,
    parameter int              WINDOW_BITS     = 28,
    parameter logic [ADDR_W-1:0] BASE_ADDR     = 32'h1000_0000,
    parameter int              MAX_OUTSTANDING = 8,
    parameter logic [3:0]      CACHE           = 4'b0011
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                s_ar_valid,
    output logic                s_ar_ready,
    input  logic [ADDR_W-1:0]   s_ar_addr,
    input  logic [ID_W-1:0]     s_ar_id,
    input  logic [7:0]          s_ar_len,
    input  logic [2:0]          s_ar_size,
    input  logic                s_aw_valid,
    output logic                s_aw_ready,
    input  logic [ADDR_W-1:0]   s_aw_addr,
    input  logic [ID_W-1:0]     s_aw_id,
    input  logic [7:0]          s_aw_len,
    input  logic [2:0]          s_aw_size,
    input  logic                s_w_valid,
    output logic                s_w_ready,
    input  logic [DATA_W-1:0]   s_w_data,
    input  logic [DATA_W/8-1:0] s_w_strb,
    input  logic                s_w_last,
    output logic                s_b_valid,
    input  logic                s_b_ready,
    output logic [ID_W-1:0]     s_b_id,
    output logic [1:0]          s_b_resp,
    output logic                s_r_valid,
    input  logic                s_r_ready,
    output logic [ID_W-1:0]     s_r_id,
    output logic [DATA_W-1:0]   s_r_data,
    output logic [1:0]          s_r_resp,
    output logic                s_r_last,
    output logic                m_ar_valid,
    input  logic                m_ar_ready,
    output logic [ADDR_W-1:0]   m_ar_addr,
    output logic [ID_W-1:0]     m_ar_id,
    output logic [7:0]          m_ar_len,
    output logic [2:0]          m_ar_size,
    output logic [1:0]          m_ar_burst,
    output logic [3:0]          m_ar_cache,
    output logic [2:0]          m_ar_prot,
    output logic [3:0]          m_ar_qos,
    output logic [3:0]          m_ar_region,
    output logic                m_ar_lock,
    output logic                m_aw_valid,
    input  logic                m_aw_ready,
    output logic [ADDR_W-1:0]   m_aw_addr,
    output logic [ID_W-1:0]     m_aw_id,
    output logic [7:0]          m_aw_len,
    output logic [2:0]          m_aw_size,
    output logic [1:0]          m_aw_burst,
    output logic [3:0]          m_aw_cache,
    output logic [2:0]          m_aw_prot,
    output logic [3:0]          m_aw_qos,
    output logic [3:0]          m_aw_region,
    output logic                m_aw_lock,
    output logic                m_w_valid,
    input  logic                m_w_ready,
    output logic [DATA_W-1:0]   m_w_data,
    output logic [DATA_W/8-1:0] m_w_strb,
    output logic                m_w_last,
    input  logic                m_b_valid,
    output logic                m_b_ready,
    input  logic [ID_W-1:0]     m_b_id,
    input  logic [1:0]          m_b_resp,
    input  logic                m_r_valid,
    output logic                m_r_ready,
    input  logic [ID_W-1:0]     m_r_id,
    input  logic [DATA_W-1:0]   m_r_data,
    input  logic [1:0]          m_r_resp,
    input  logic                m_r_last,
    input  logic                drain_req,
    output logic                idle,
    output logic                addr_oob,
    output logic                resp_err
);
    localparam logic [ADDR_W-1:0] WIN_MASK = ADDR_W'((64'd1 << WINDOW_BITS) - 64'd1);
    localparam int PW   = ADDR_W + ID_W + 8 + 3;
    localparam int CNTW = $clog2(MAX_OUTSTANDING + 1);

    if ((BASE_ADDR & WIN_MASK) != '0) begin : g_bad_base
        $error("BASE_ADDR must have its low WINDOW_BITS bits clear");
    end
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 255) begin : g_bad_max
        $error("MAX_OUTSTANDING must lie in 1..255");
    end

    logic [PW-1:0] ar_in, ar_out, aw_in, aw_out;
    logic ar_empty, aw_empty, rd_allow, wr_allow, rd_zero, wr_zero;
    logic rd_uf, wr_uf, ar_hs, aw_hs, m_ar_hs, m_aw_hs, r_last_hs, b_hs;
    logic idle_q, addr_oob_q, resp_err_q;

    // Relocation happens before the skid so the stored address is already the DDR address.
    assign ar_in = {BASE_ADDR | (s_ar_addr & WIN_MASK), s_ar_id, s_ar_len, s_ar_size};
    assign aw_in = {BASE_ADDR | (s_aw_addr & WIN_MASK), s_aw_id, s_aw_len, s_aw_size};
    assign {m_ar_addr, m_ar_id, m_ar_len, m_ar_size} = ar_out;
    assign {m_aw_addr, m_aw_id, m_aw_len, m_aw_size} = aw_out;

    hp_port_remap_skid #(.W(PW)) u_ar_skid (
        .clk_i(clock), .rst_ni(reset_n), .drain_i(drain_req),
        .in_valid_i(s_ar_valid), .in_ready_o(s_ar_ready), .in_data_i(ar_in),
        .issue_en_i(rd_allow), .out_valid_o(m_ar_valid), .out_ready_i(m_ar_ready),
        .out_data_o(ar_out), .empty_o(ar_empty)
    );

    hp_port_remap_skid #(.W(PW)) u_aw_skid (
        .clk_i(clock), .rst_ni(reset_n), .drain_i(drain_req),
        .in_valid_i(s_aw_valid), .in_ready_o(s_aw_ready), .in_data_i(aw_in),
        .issue_en_i(wr_allow), .out_valid_o(m_aw_valid), .out_ready_i(m_aw_ready),
        .out_data_o(aw_out), .empty_o(aw_empty)
    );

    assign ar_hs     = s_ar_valid && s_ar_ready;
    assign aw_hs     = s_aw_valid && s_aw_ready;
    assign m_ar_hs   = m_ar_valid && m_ar_ready;
    assign m_aw_hs   = m_aw_valid && m_aw_ready;
    assign r_last_hs = m_r_valid && s_r_ready && m_r_last;
    assign b_hs      = m_b_valid && s_b_ready;

    hp_port_remap_ostd #(.MAX(MAX_OUTSTANDING), .CW(CNTW)) u_rd_cnt (
        .clk_i(clock), .rst_ni(reset_n), .inc_i(m_ar_hs), .dec_i(r_last_hs),
        .allow_o(rd_allow), .zero_o(rd_zero), .underflow_o(rd_uf)
    );

    hp_port_remap_ostd #(.MAX(MAX_OUTSTANDING), .CW(CNTW)) u_wr_cnt (
        .clk_i(clock), .rst_ni(reset_n), .inc_i(m_aw_hs), .dec_i(b_hs),
        .allow_o(wr_allow), .zero_o(wr_zero), .underflow_o(wr_uf)
    );

    assign m_ar_burst  = 2'b01;
    assign m_ar_cache  = CACHE;
    assign m_ar_prot   = 3'd0;
    assign m_ar_qos    = 4'd0;
    assign m_ar_region = 4'd0;
    assign m_ar_lock   = 1'b0;
    assign m_aw_burst  = 2'b01;
    assign m_aw_cache  = CACHE;
    assign m_aw_prot   = 3'd0;
    assign m_aw_qos    = 4'd0;
    assign m_aw_region = 4'd0;
    assign m_aw_lock   = 1'b0;

    // Data and response channels are untouched; W may legally run ahead of AW.
    assign m_w_valid = s_w_valid;
    assign s_w_ready = m_w_ready;
    assign m_w_data  = s_w_data;
    assign m_w_strb  = s_w_strb;
    assign m_w_last  = s_w_last;
    assign s_b_valid = m_b_valid;
    assign m_b_ready = s_b_ready;
    assign s_b_id    = m_b_id;
    assign s_b_resp  = m_b_resp;
    assign s_r_valid = m_r_valid;
    assign m_r_ready = s_r_ready;
    assign s_r_id    = m_r_id;
    assign s_r_data  = m_r_data;
    assign s_r_resp  = m_r_resp;
    assign s_r_last  = m_r_last;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idle_q     <= 1'b1;
            addr_oob_q <= 1'b0;
            resp_err_q <= 1'b0;
        end else begin
            idle_q     <= ar_empty && aw_empty && rd_zero && wr_zero;
            addr_oob_q <= addr_oob_q
                          || (ar_hs && ((s_ar_addr & ~WIN_MASK) != '0))
                          || (aw_hs && ((s_aw_addr & ~WIN_MASK) != '0));
            resp_err_q <= resp_err_q || rd_uf || wr_uf;
        end
    end

    assign idle     = idle_q;
    assign addr_oob = addr_oob_q;
    assign resp_err = resp_err_q;
endmodule
